sdram_mport_arbit: RTL
======================

# sdram_mport_arbit

Parametrised multi-port command arbiter and SDRAM bus driver; the next generation of the fixed init/refresh/write/read controller top. It multiplexes an initialisation engine, an auto-refresh engine and NUM_CH generic read/write channel engines onto one SDRAM command, address and data bus. Channels are granted in round-robin order, with refresh taking priority at every arbitration point. A grant watchdog revokes a channel that never reports completion. The block sits between the per-function SDRAM engines and the SDRAM pins.

## Interface
- NUM_CH, 4: number of channel engines (1..8)
- ADDR_W, 12: SDRAM address bus width
- BA_W, 2: bank address width
- DQ_W, 16: data bus width
- GRANT_TMO, 1024: maximum cycles a channel may hold a grant
- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst  in  1  synchronous reset, active-high
- init_end  in  1  initialisation complete (level)
- init_cmd / init_ba / init_addr  in  4 / BA_W / ADDR_W  init engine command bus
- aref_req  in  1  refresh request (level, held until served)
- aref_end  in  1  refresh sequence done (1-cycle pulse)
- aref_cmd / aref_ba / aref_addr  in  4 / BA_W / ADDR_W  refresh engine command bus
- aref_en  out  1  refresh engine enable
- ch_req  in  NUM_CH  channel request (level)
- ch_end  in  NUM_CH  channel transaction done (1-cycle pulse)
- ch_cmd / ch_ba / ch_addr  in  NUM_CH×4 / NUM_CH×BA_W / NUM_CH×ADDR_W  packed channel command buses; channel i occupies slice i
- ch_dq_oe  in  NUM_CH  channel requests to drive dq
- ch_wdata  in  NUM_CH×DQ_W  packed channel write data
- ch_grant  out  NUM_CH  one-hot grant
- rd_data  out  DQ_W  registered dq sample
- err_tmo  out  1  sticky watchdog flag
- err_ch  out  3  index of the last timed-out channel
- sdram_cke / sdram_cs_n / sdram_ras_n / sdram_cas_n / sdram_we_n  out  1 each  SDRAM control pins
- sdram_ba / sdram_addr  out  BA_W / ADDR_W  SDRAM bank and address pins
- sdram_dq  inout  DQ_W  SDRAM data bus

## Operation
- States:
  - INIT: wait for initialisation.
  - ARB: choose the next owner.
  - AREF: refresh in progress.
  - GRANT: a channel owns the bus.
- INIT -> ARB when init_end=1. aref_req and ch_req are ignored while in INIT.
- ARB -> AREF if aref_req=1. Refresh beats all channels.
- ARB -> GRANT otherwise, if any ch_req bit is set. The winner is the first set bit searched upward from (last granted index + 1) mod NUM_CH. Else ARB is held.
- AREF -> ARB on aref_end.
- GRANT -> ARB on ch_end[g], where g is the granted channel. ch_end from any non-granted channel is ignored.
- In GRANT, the grant is held until ch_end[g] even if ch_req[g] drops. The round-robin pointer is set to g when the grant is issued.
- Watchdog:
  - A counter clears on GRANT entry and increments every GRANT cycle.
  - When it reaches GRANT_TMO without ch_end[g]: go to ARB, set err_tmo (sticky until reset), load err_ch=g.
  - If ch_end[g] and the timeout occur in the same cycle, it is a normal end and no error is flagged.
- Command mux is combinational from the state registers:
  - INIT: init_*.
  - AREF: aref_*.
  - GRANT: slice g of ch_*.
  - ARB: NOP, i.e. cmd=4'b0111, ba all ones, addr all ones.
- {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = selected cmd[3:0]. sdram_cke = 1 except during reset.
- sdram_dq is driven with slice g of ch_wdata only when state=GRANT and ch_dq_oe[g]=1. Otherwise it is high-Z.
- rd_data <= sdram_dq on every cycle.

## Timing
- Reset values:
  - State INIT, ch_grant=0, aref_en=0, round-robin pointer=NUM_CH-1 (so channel 0 wins first).
  - err_tmo=0, err_ch=0, rd_data=0.
  - Command bus NOP, sdram_cke=0, sdram_dq high-Z.
- Reset mid-transaction drops the grant and aref_en at the same edge.
- init_end high at cycle t -> ARB at t+1. The earliest grant or aref_en is at t+2.
- Request seen in ARB at cycle t -> ch_grant (or aref_en) high at t+1. The owner's command appears on the pins in that same cycle t+1.
- ch_end[g] or aref_end at cycle t -> grant/enable low at t+1 (state ARB). The next owner is granted at t+2. The minimum gap is one NOP cycle.
- aref_req and ch_req both pending in ARB: refresh is served first. The channel is served after aref_end, and the round-robin pointer is unchanged by the refresh.
- rd_data latency: 1 cycle after the pin value.

## Test plan
- Reset release with init_end asserted at cycle 10 -> pins show init_cmd through cycle 10, NOP at 11, ch_grant stays 0 at 11.
- ch_req=4'b1111 held, each channel pulsing ch_end 5 cycles after its grant -> grant sequence 0,1,2,3,0; one NOP cycle between grants.
- ch_req=4'b0101, aref_req raised during channel 0's grant -> sequence ch0, AREF (aref_en until aref_end), ch2.
- Channel 1 granted, never pulses ch_end, GRANT_TMO=16 -> grant drops 16 cycles after grant start; err_tmo=1, err_ch=1; channel 2 is served next.
- Granted channel 3 with ch_dq_oe=1 and ch_wdata=16'hA5C3 -> sdram_dq=16'hA5C3 during the grant, high-Z afterwards. An external driver of 16'h1234 while idle -> rd_data=16'h1234 one cycle later.
- sys_rst pulsed during a GRANT -> next edge: ch_grant=0, sdram_cke=0, err flags cleared, state INIT.

Source files
------------

// File: rtl/sdram_mport_arbit_if.sv
// Channel-engine side of the SDRAM multi-port arbiter: packed per-channel
// command/data buses plus the one-hot grant returned by the arbiter.
interface sdram_mport_arbit_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 12,
  parameter int BA_W   = 2,
  parameter int DQ_W   = 16
);
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_end;
  logic [NUM_CH*4-1:0]      ch_cmd;
  logic [NUM_CH*BA_W-1:0]   ch_ba;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0]        ch_dq_oe;
  logic [NUM_CH*DQ_W-1:0]   ch_wdata;
  logic [NUM_CH-1:0]        ch_grant;

  // Channel engines drive requests and buses, and receive the grant.
  modport master (
    output ch_req, ch_end, ch_cmd, ch_ba, ch_addr, ch_dq_oe, ch_wdata,
    input  ch_grant
  );

  // Arbiter consumes the channel buses and issues the grant.
  modport slave (
    input  ch_req, ch_end, ch_cmd, ch_ba, ch_addr, ch_dq_oe, ch_wdata,
    output ch_grant
  );
endinterface

// File: rtl/sdram_mport_arbit.sv
// Multi-port SDRAM command arbiter: init, auto-refresh and NUM_CH round-robin
// channels share one SDRAM command/address/data bus, with a grant watchdog.
module sdram_mport_arbit #(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 12,
  parameter int BA_W      = 2,
  parameter int DQ_W      = 16,
  parameter int GRANT_TMO = 1024
) (
  input  logic              sys_clk,
  input  logic              sys_rst,

  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,

  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  output logic              aref_en,

  sdram_mport_arbit_if.slave ch_if,

  output logic [DQ_W-1:0]   rd_data,
  output logic              err_tmo,
  output logic [2:0]        err_ch,

  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  inout  wire  [DQ_W-1:0]   sdram_dq
);

  localparam int MAX_CH = 8;
  localparam int TMO_W  = $clog2(GRANT_TMO + 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_ARB,
    S_AREF,
    S_GRANT
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        gnt_idx_q, gnt_idx_d;
  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic [TMO_W-1:0]  wdog_q, wdog_d;
  logic              err_tmo_q, err_tmo_d;
  logic [2:0]        err_ch_q, err_ch_d;
  logic [DQ_W-1:0]   rd_data_q;
  logic              cke_q;

  logic [3:0]        cmd_arr   [MAX_CH];
  logic [BA_W-1:0]   ba_arr    [MAX_CH];
  logic [ADDR_W-1:0] addr_arr  [MAX_CH];
  logic [DQ_W-1:0]   wdata_arr [MAX_CH];
  logic [MAX_CH-1:0] req_vec;
  logic [MAX_CH-1:0] end_vec;
  logic [MAX_CH-1:0] oe_vec;

  logic [2:0]        cand_idx  [MAX_CH];
  logic [MAX_CH-1:0] cand_hit;
  logic              win_found;
  logic [2:0]        win_idx;

  logic [3:0]        cmd_sel;
  logic [BA_W-1:0]   ba_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic              dq_drive;

  // Unpack channel slices into fixed 8-entry tables so a 3-bit index always fits.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_CH; gi++) begin : g_unpack
      if (gi < NUM_CH) begin : g_used
        assign cmd_arr[gi]   = ch_if.ch_cmd[gi*4 +: 4];
        assign ba_arr[gi]    = ch_if.ch_ba[gi*BA_W +: BA_W];
        assign addr_arr[gi]  = ch_if.ch_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = ch_if.ch_wdata[gi*DQ_W +: DQ_W];
        assign req_vec[gi]   = ch_if.ch_req[gi];
        assign end_vec[gi]   = ch_if.ch_end[gi];
        assign oe_vec[gi]    = ch_if.ch_dq_oe[gi];
      end else begin : g_pad
        assign cmd_arr[gi]   = '0;
        assign ba_arr[gi]    = '0;
        assign addr_arr[gi]  = '0;
        assign wdata_arr[gi] = '0;
        assign req_vec[gi]   = 1'b0;
        assign end_vec[gi]   = 1'b0;
        assign oe_vec[gi]    = 1'b0;
      end
    end
  endgenerate

  // Candidate gi is the channel (rr_ptr + 1 + gi) mod NUM_CH; lowest hit wins.
  generate
    for (gi = 0; gi < MAX_CH; gi++) begin : g_rr
      if (gi < NUM_CH) begin : g_used
        logic [3:0] sum;
        assign sum           = {1'b0, rr_ptr_q} + 4'(gi + 1);
        assign cand_idx[gi]  = (sum >= 4'(NUM_CH)) ? 3'(sum - 4'(NUM_CH)) : sum[2:0];
        assign cand_hit[gi]  = req_vec[cand_idx[gi]];
      end else begin : g_pad
        assign cand_idx[gi]  = '0;
        assign cand_hit[gi]  = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    win_found = |cand_hit;
    win_idx   = '0;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        win_idx = cand_idx[k];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    rr_ptr_d  = rr_ptr_q;
    wdog_d    = wdog_q;
    err_tmo_d = err_tmo_q;
    err_ch_d  = err_ch_q;
    case (state_q)
      S_INIT: begin
        if (init_end) begin
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        if (aref_req) begin
          state_d = S_AREF;
        end else if (win_found) begin
          state_d   = S_GRANT;
          gnt_idx_d = win_idx;
          rr_ptr_d  = win_idx;
          wdog_d    = '0;
        end
      end
      S_AREF: begin
        if (aref_end) begin
          state_d = S_ARB;
        end
      end
      S_GRANT: begin
        wdog_d = wdog_q + TMO_W'(1);
        // A completion in the timeout cycle still counts as a normal end.
        if (end_vec[gnt_idx_q]) begin
          state_d = S_ARB;
        end else if (wdog_q == TMO_W'(GRANT_TMO - 1)) begin
          state_d   = S_ARB;
          err_tmo_d = 1'b1;
          err_ch_d  = gnt_idx_q;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= S_INIT;
      gnt_idx_q <= '0;
      rr_ptr_q  <= 3'(NUM_CH - 1);
      wdog_q    <= '0;
      err_tmo_q <= 1'b0;
      err_ch_q  <= '0;
      rd_data_q <= '0;
      cke_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      rr_ptr_q  <= rr_ptr_d;
      wdog_q    <= wdog_d;
      err_tmo_q <= err_tmo_d;
      err_ch_q  <= err_ch_d;
      rd_data_q <= sdram_dq;
      cke_q     <= 1'b1;
    end
  end

  // Pins stay at NOP until the clock enable has come up after reset.
  always_comb begin
    cmd_sel  = 4'b0111;
    ba_sel   = '1;
    addr_sel = '1;
    if (cke_q) begin
      case (state_q)
        S_INIT: begin
          cmd_sel  = init_cmd;
          ba_sel   = init_ba;
          addr_sel = init_addr;
        end
        S_AREF: begin
          cmd_sel  = aref_cmd;
          ba_sel   = aref_ba;
          addr_sel = aref_addr;
        end
        S_GRANT: begin
          cmd_sel  = cmd_arr[gnt_idx_q];
          ba_sel   = ba_arr[gnt_idx_q];
          addr_sel = addr_arr[gnt_idx_q];
        end
        default: begin
        end
      endcase
    end
  end

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_grant
      assign ch_if.ch_grant[gi] = (state_q == S_GRANT) && (gnt_idx_q == 3'(gi));
    end
  endgenerate

  assign dq_drive = (state_q == S_GRANT) && oe_vec[gnt_idx_q];
  assign sdram_dq = dq_drive ? wdata_arr[gnt_idx_q] : {DQ_W{1'bz}};

  assign aref_en     = (state_q == S_AREF);
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_sel;
  assign sdram_ba    = ba_sel;
  assign sdram_addr  = addr_sel;
  assign sdram_cke   = cke_q;
  assign rd_data     = rd_data_q;
  assign err_tmo     = err_tmo_q;
  assign err_ch      = err_ch_q;

endmodule
